dmem_resp: RTL and testbench

Data-memory responder serving the MEM stage's data-memory port (`dmem_addr`, `dmem_wr_data`, `dmem_wr_en`, `dmem_rd_en`, `dmem_mask` in; `dmem_rd_data` out). It holds the word-organised data RAM and decodes addresses into RAM, optional MMIO, or out-of-range. It flags misaligned and out-of-range accesses in a sticky fault register. The MEM stage performs its own read-modify-write for byte and halfword stores, so this block always returns the addressed word combinationally and writes whole words.

---
 rtl/dmem_resp_pkg.sv | 29 ++
 rtl/defines.sv | 10 +
 rtl/dmem_ram.sv | 24 ++
 rtl/dmem_resp.sv | 169 ++++++++++++++++
 tb/tb_dmem_resp.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// Fault encodings, MMIO offsets, region type and alignment helper for dmem_resp.
`ifndef MASK_W
`include "defines.sv"
`endif

package dmem_resp_pkg;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam logic [3:0]  MMIO_OFF_CNT   = 4'h0;
    localparam logic [3:0]  MMIO_OFF_GPIO  = 4'h4;
    localparam logic [3:0]  MMIO_OFF_FAULT = 4'h8;
    localparam logic [31:0] MMIO_SPAN      = 32'hC;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_e;

    function automatic logic misaligned(input logic [`MASK_WIDTH-1:0] mask,
                                        input logic [1:0]             lo);
        return ((mask == `MASK_W) && (lo != 2'b00)) ||
               ((mask == `MASK_H) && lo[0]);
    endfunction

endpackage

// File: rtl/defines.sv
// Shared width and access-size macros used by the MEM stage and its memory ports.
`ifndef DEFINES_SV
`define DEFINES_SV
`define MEM_ADDR_WIDTH 32
`define REG_DATA_WIDTH 32
`define MASK_WIDTH     2
`define MASK_B         2'b00
`define MASK_H         2'b01
`define MASK_W         2'b10
`endif

// File: rtl/dmem_ram.sv
// Word-organised data RAM: asynchronous read, synchronous whole-word write, no reset.
module dmem_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: RAM/MMIO/out-of-range decode with a sticky fault register.
// Define DMEM_MMIO_EN to add the cycle counter, gpio_out and fault-status MMIO window.
`ifndef MASK_W
`include "defines.sv"
`endif

module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`MEM_ADDR_WIDTH-1:0] dmem_addr,
    input  logic [`REG_DATA_WIDTH-1:0] dmem_wr_data,
    input  logic                       dmem_wr_en,
    input  logic                       dmem_rd_en,
    input  logic [`MASK_WIDTH-1:0]     dmem_mask,
    input  logic                       fault_clr,
    output logic [`REG_DATA_WIDTH-1:0] dmem_rd_data,
    output logic                       fault,
    output logic [1:0]                 fault_cause,
    output logic [`MEM_ADDR_WIDTH-1:0] fault_addr
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0]                gpio_out
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    region_e                    region;
    logic                       in_ram;
    logic                       in_mmio;
    logic                       access;
    logic                       misal;
    logic                       wr_ok;
    logic                       new_fault;
    logic                       clr_any;
    logic                       mmio_clr;
    logic [`MEM_ADDR_WIDTH-1:0] mmio_off;
    logic [`REG_DATA_WIDTH-1:0] ram_rdata;

    logic                       fault_q, fault_d;
    logic [1:0]                 cause_q, cause_d;
    logic [`MEM_ADDR_WIDTH-1:0] faddr_q, faddr_d;

    assign mmio_off = dmem_addr - MMIO_BASE;
    assign in_mmio  = (dmem_addr >= MMIO_BASE) && (mmio_off < MMIO_SPAN);
    assign in_ram   = {2'b00, dmem_addr[`MEM_ADDR_WIDTH-1:2]} < DEPTH;

    always_comb begin
        region = REGION_NONE;
        if (in_ram) begin
            region = REGION_RAM;
        end
`ifdef DMEM_MMIO_EN
        else if (in_mmio) begin
            region = REGION_MMIO;
        end
`endif
    end

    assign access    = dmem_rd_en | dmem_wr_en;
    assign misal     = misaligned(dmem_mask, dmem_addr[1:0]);
    assign wr_ok     = dmem_wr_en & ~misal & ~rst;
    assign new_fault = access && (misal || (region == REGION_NONE));
    assign clr_any   = fault_clr | mmio_clr;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (`REG_DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_ok && (region == REGION_RAM)),
        .addr_i  (dmem_addr[AW+1:2]),
        .wdata_i (dmem_wr_data),
        .rdata_o (ram_rdata)
    );

`ifdef DMEM_MMIO_EN
    logic [31:0]                cnt_q;
    logic [31:0]                gpio_q;
    logic                       mmio_wr;
    logic [3:0]                 mmio_word;
    logic [`REG_DATA_WIDTH-1:0] mmio_rdata;

    // Misaligned MMIO reads resolve to the containing word, like RAM.
    assign mmio_word = {mmio_off[3:2], 2'b00};
    assign mmio_wr   = wr_ok && (region == REGION_MMIO);
    assign mmio_clr  = mmio_wr && (mmio_word == MMIO_OFF_FAULT) && dmem_wr_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gpio_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (mmio_wr && (mmio_word == MMIO_OFF_GPIO)) begin
                gpio_q <= dmem_wr_data;
            end
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_word)
            MMIO_OFF_CNT:   mmio_rdata = cnt_q;
            MMIO_OFF_GPIO:  mmio_rdata = gpio_q;
            MMIO_OFF_FAULT: mmio_rdata = {28'b0, cause_q, 1'b0, fault_q};
            default:        mmio_rdata = '0;
        endcase
    end

    assign gpio_out = gpio_q;
`else
    logic unused_mmio;

    assign mmio_clr    = 1'b0;
    assign unused_mmio = in_mmio;
`endif

    always_comb begin
        dmem_rd_data = '0;
        case (region)
            REGION_RAM:  dmem_rd_data = ram_rdata;
`ifdef DMEM_MMIO_EN
            REGION_MMIO: dmem_rd_data = mmio_rdata;
`endif
            default:     dmem_rd_data = '0;
        endcase
    end

    // A clear and a new fault in the same cycle: the new fault is captured.
    always_comb begin
        fault_d = fault_q;
        cause_d = cause_q;
        faddr_d = faddr_q;
        if (clr_any) begin
            fault_d = 1'b0;
            cause_d = FAULT_NONE;
            faddr_d = '0;
        end
        if (new_fault && (!fault_q || clr_any)) begin
            fault_d = 1'b1;
            cause_d = misal ? FAULT_MISALIGN : FAULT_RANGE;
            faddr_d = dmem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
            cause_q <= FAULT_NONE;
            faddr_q <= '0;
        end else begin
            fault_q <= fault_d;
            cause_q <= cause_d;
            faddr_q <= faddr_d;
        end
    end

    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_addr  = faddr_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: stimulus queues expected values, a negedge monitor checks them.
`ifndef MASK_W
`include "defines.sv"
`endif

module tb_dmem_resp;

    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
    localparam logic [1:0]  MW = `MASK_W;
    localparam logic [1:0]  MH = `MASK_H;
    localparam logic [1:0]  MB = `MASK_B;

    localparam int S_RD    = 0;
    localparam int S_FAULT = 1;
    localparam int S_CAUSE = 2;
    localparam int S_FADDR = 3;
    localparam int S_GPIO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wr_data = '0;
    logic        dmem_wr_en = 1'b0;
    logic        dmem_rd_en = 1'b0;
    logic [1:0]  dmem_mask = `MASK_W;
    logic        fault_clr = 1'b0;
    logic [31:0] dmem_rd_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;
`ifdef DMEM_MMIO_EN
    logic [31:0] gpio_out;
`endif

    always #5 clk = ~clk;

    dmem_resp #(
        .DEPTH     (4096),
        .MMIO_BASE (MMIO_BASE)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_addr    (dmem_addr),
        .dmem_wr_data (dmem_wr_data),
        .dmem_wr_en   (dmem_wr_en),
        .dmem_rd_en   (dmem_rd_en),
        .dmem_mask    (dmem_mask),
        .fault_clr    (fault_clr),
        .dmem_rd_data (dmem_rd_data),
        .fault        (fault),
        .fault_cause  (fault_cause),
        .fault_addr   (fault_addr)
`ifdef DMEM_MMIO_EN
        ,
        .gpio_out     (gpio_out)
`endif
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mcnt = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) mcnt <= '0;
        else     mcnt <= mcnt + 32'd1;
    end

    function automatic string sig_name(input int s);
        case (s)
            S_RD:    return "rd_data";
            S_FAULT: return "fault";
            S_CAUSE: return "fault_cause";
            S_FADDR: return "fault_addr";
            default: return "gpio_out";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int s);
        case (s)
            S_RD:    return dmem_rd_data;
            S_FAULT: return {31'b0, fault};
            S_CAUSE: return {30'b0, fault_cause};
            S_FADDR: return fault_addr;
`ifdef DMEM_MMIO_EN
            S_GPIO:  return gpio_out;
`endif
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: checks every entry due this cycle; entries whose cycle has passed are late.
    always @(negedge clk) begin
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = actual(sb[i].sig);
                checks++;
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", sig_name(sb[i].sig), cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL late_%s cyc=%0d got=unchecked exp=%h", sig_name(sb[i].sig), cyc, sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic re, input logic [1:0] m, input logic clr);
        @(posedge clk);
        #1;
        rst          = r;
        dmem_addr    = a;
        dmem_wr_data = d;
        dmem_wr_en   = we;
        dmem_rd_en   = re;
        dmem_mask    = m;
        fault_clr    = clr;
    endtask

    task automatic idle(input logic clr);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, MW, clr);
    endtask

    task automatic expect_sig(input int s, input logic [31:0] v, input int delay);
        exp_t e;
        e.cyc = cyc + delay;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_status(input logic f, input logic [1:0] c, input logic [31:0] a,
                                 input int delay);
        expect_sig(S_FAULT, {31'b0, f}, delay);
        expect_sig(S_CAUSE, {30'b0, c}, delay);
        expect_sig(S_FADDR, a, delay);
    endtask

    initial begin
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, MW, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, MW, 1'b0);
        idle(1'b0);
        expect_status(1'b0, 2'b00, 32'h0, 0);

        // Word write, then overwrite with rd+wr: old word visible in the write cycle.
        drive(1'b0, 32'h10, 32'h1111_1111, 1'b1, 1'b0, MW, 1'b0);
        drive(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, MW, 1'b0);
        expect_sig(S_RD, 32'h1111_1111, 0);
        drive(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, 32'hDEAD_BEEF, 0);
        expect_status(1'b0, 2'b00, 32'h0, 0);

        // Misaligned word write is dropped and faults.
        drive(1'b0, 32'h12, 32'hCAFE_F00D, 1'b1, 1'b0, MW, 1'b0);
        expect_status(1'b1, 2'b01, 32'h12, 1);
        drive(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, MW, 1'b0);
        expect_sig(S_RD, 32'hDEAD_BEEF, 0);

        // Later out-of-range read does not overwrite the captured fault.
        drive(1'b0, 32'h4000, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, 32'h0, 0);
        expect_status(1'b1, 2'b01, 32'h12, 1);

        // Clear and new fault in the same cycle: new fault captured.
        drive(1'b0, 32'h2000_0000, 32'h0, 1'b0, 1'b1, MW, 1'b1);
        expect_status(1'b1, 2'b10, 32'h2000_0000, 1);
        idle(1'b1);
        expect_status(1'b0, 2'b00, 32'h0, 1);

        // Misaligned address without enables: aligned word, no fault.
        drive(1'b0, 32'h13, 32'h0, 1'b0, 1'b0, MW, 1'b0);
        expect_sig(S_RD, 32'hDEAD_BEEF, 0);
        expect_status(1'b0, 2'b00, 32'h0, 1);

        // Halfword store writes the whole merged word; misaligned halfword read faults.
        drive(1'b0, 32'h22, 32'h1234_5678, 1'b1, 1'b0, MH, 1'b0);
        expect_status(1'b0, 2'b00, 32'h0, 1);
        drive(1'b0, 32'h21, 32'h0, 1'b0, 1'b1, MH, 1'b0);
        expect_sig(S_RD, 32'h1234_5678, 0);
        expect_status(1'b1, 2'b01, 32'h21, 1);
        idle(1'b1);
        expect_status(1'b0, 2'b00, 32'h0, 1);
        drive(1'b0, 32'h23, 32'h0, 1'b0, 1'b1, MB, 1'b0);
        expect_sig(S_RD, 32'h1234_5678, 0);
        expect_status(1'b0, 2'b00, 32'h0, 1);

        // Misaligned and out-of-range together reports misaligned.
        drive(1'b0, 32'h4002, 32'h0, 1'b1, 1'b0, MW, 1'b0);
        expect_status(1'b1, 2'b01, 32'h4002, 1);
        idle(1'b1);
        expect_status(1'b0, 2'b00, 32'h0, 1);

        // Out-of-range write is dropped (would alias word 4 if decoded by low bits).
        drive(1'b0, 32'h4010, 32'h0BAD_F00D, 1'b1, 1'b0, MW, 1'b0);
        expect_status(1'b1, 2'b10, 32'h4010, 1);
        drive(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, MW, 1'b0);
        expect_sig(S_RD, 32'hDEAD_BEEF, 0);

        // Reset during a write and during a faulting access.
        drive(1'b1, 32'h20, 32'hBAD0_BAD0, 1'b1, 1'b0, MW, 1'b0);
        drive(1'b1, 32'h4001, 32'h0, 1'b1, 1'b1, MW, 1'b0);
        drive(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, MW, 1'b0);
        expect_sig(S_RD, 32'h1234_5678, 0);
        expect_status(1'b0, 2'b00, 32'h0, 0);

`ifdef DMEM_MMIO_EN
        expect_sig(S_GPIO, 32'h0, 0);
        drive(1'b0, MMIO_BASE + 32'h4, 32'h0000_00A5, 1'b1, 1'b0, MW, 1'b0);
        expect_sig(S_GPIO, 32'h0000_00A5, 1);
        expect_status(1'b0, 2'b00, 32'h0, 1);
        drive(1'b0, MMIO_BASE, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, mcnt, 0);
        drive(1'b0, MMIO_BASE, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, mcnt, 0);
        drive(1'b0, 32'h4000, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_status(1'b1, 2'b10, 32'h4000, 1);
        drive(1'b0, MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, 32'h0000_0009, 0);
        drive(1'b0, MMIO_BASE + 32'h8, 32'h0000_0001, 1'b1, 1'b0, MW, 1'b0);
        expect_status(1'b0, 2'b00, 32'h0, 1);
        drive(1'b0, MMIO_BASE, 32'h5555_5555, 1'b1, 1'b0, MW, 1'b0);
        expect_status(1'b0, 2'b00, 32'h0, 1);
        drive(1'b0, MMIO_BASE, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, mcnt, 0);
        drive(1'b0, MMIO_BASE + 32'h2, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, mcnt, 0);
        expect_status(1'b1, 2'b01, MMIO_BASE + 32'h2, 1);
        idle(1'b1);
        expect_status(1'b0, 2'b00, 32'h0, 1);

        // Counter wrap.
        drive(1'b0, MMIO_BASE, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        force u_dut.cnt_q = 32'hFFFF_FFFF;
        expect_sig(S_RD, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        #2;
        release u_dut.cnt_q;
        drive(1'b0, MMIO_BASE, 32'h0, 1'b0, 1'b1, MW, 1'b0);
        expect_sig(S_RD, 32'h0, 0);
`endif

        idle(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
